// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern ROM arbiter.
package pattern_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 4;

  localparam logic REQ_FRAME  = 1'b0;
  localparam logic REQ_SPRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_P0     = 2'd1,
    ARB_P1     = 2'd2,
    ARB_FORCE1 = 2'd3
  } arb_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/rom_tag_pipe.sv
// Tracks {valid, owner} of each ROM read through the ROM latency.
module rom_tag_pipe #(
  parameter int ROM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [ROM_LAT-1:0] vld;
  logic [ROM_LAT-1:0] own;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      own <= '0;
    end else begin
      vld[0] <= in_valid;
      own[0] <= in_owner;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld[i] <= vld[i-1];
        own[i] <= own[i-1];
      end
    end
  end

  assign out_valid = vld[ROM_LAT-1];
  assign out_owner = own[ROM_LAT-1];

endmodule

// File: rtl/pattern_rom_arbiter.sv
// Shares one single-port pattern ROM between the frame renderer (req0)
// and the sprite/text drawer (req1); req1 gets a forced slot after MAX_WAIT losses.
//
// state      | meaning
// ARB_IDLE   | no request seen last cycle
// ARB_P0     | req0 present, req0 has priority
// ARB_P1     | only req1 present, req1 served
// ARB_FORCE1 | req1 lost MAX_WAIT times in a row; next slot belongs to req1
module pattern_rom_arbiter
  import pattern_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [3:0]        starve_cnt
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win0, win1;
  logic             rom_owner;
  logic             tag_valid, tag_owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win0    = 1'b0;
    win1    = 1'b0;

    case (state_q)
      ARB_FORCE1: begin
        if (req1)      win1 = 1'b1;
        else if (req0) win0 = 1'b1;
      end
      default: begin
        if (req0)      win0 = 1'b1;
        else if (req1) win1 = 1'b1;
      end
    endcase

    if (win1 || !req1) cnt_d = '0;
    else               cnt_d = sat_inc(cnt_q, MAX_WAIT_C);

    // Entering FORCE1 only makes sense while req1 is still waiting.
    if (req1 && cnt_d == MAX_WAIT_C) state_d = ARB_FORCE1;
    else if (req0)                   state_d = ARB_P0;
    else if (req1)                   state_d = ARB_P1;
    else                             state_d = ARB_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rom_owner <= REQ_FRAME;
    end else begin
      gnt0      <= win0;
      gnt1      <= win1;
      rom_en    <= win0 | win1;
      rom_owner <= win1 ? REQ_SPRITE : REQ_FRAME;
      if (win0)      rom_addr <= addr0;
      else if (win1) rom_addr <= addr1;
    end
  end

  // Tag enters alongside the registered rom_en so it lines up with rom_data.
  rom_tag_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rom_en),
    .in_owner  (rom_owner),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag_valid && (tag_owner == REQ_FRAME);
      rvalid1 <= tag_valid && (tag_owner == REQ_SPRITE);
      if (tag_valid && tag_owner == REQ_FRAME)  rdata0 <= rom_data;
      if (tag_valid && tag_owner == REQ_SPRITE) rdata1 <= rom_data;
    end
  end

  assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_rom_arbiter.sv
// Scoreboard bench: two arbiters (ROM_LAT 1 and 3) share stimulus and a grant-level reference model.
module tb_pattern_rom_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int LAT_A    = 1;
  localparam int LAT_B    = 3;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic        g0;
    logic        g1;
    logic [10:0] a;
    logic [3:0]  sc;
  } gexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [10:0] addr0 = '0, addr1 = '0;

  logic [1:0]  gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, rom_en_v;
  logic [7:0]  rdata0_v [2];
  logic [7:0]  rdata1_v [2];
  logic [10:0] rom_addr_v [2];
  logic [7:0]  rom_data_v [2];
  logic [3:0]  starve_v [2];

  logic [7:0]  rom_img [2048];
  logic [7:0]  pa [LAT_A];
  logic [7:0]  pb [LAT_B];

  exp_t        sb [2][2][$];
  gexp_t       gq [$];
  logic [7:0]  last [2][2];
  logic [10:0] jobs0 [$];
  logic [10:0] jobs1 [$];
  int          drop_pct = 0;
  int          cyc = 0;
  int          waitc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pattern_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(LAT_A), .MAX_WAIT(MAX_WAIT)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_v[0]), .rvalid0(rvalid0_v[0]), .rdata0(rdata0_v[0]),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_v[0]), .rvalid1(rvalid1_v[0]), .rdata1(rdata1_v[0]),
    .rom_en(rom_en_v[0]), .rom_addr(rom_addr_v[0]), .rom_data(rom_data_v[0]),
    .starve_cnt(starve_v[0])
  );

  pattern_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(LAT_B), .MAX_WAIT(MAX_WAIT)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_v[1]), .rvalid0(rvalid0_v[1]), .rdata0(rdata0_v[1]),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_v[1]), .rvalid1(rvalid1_v[1]), .rdata1(rdata1_v[1]),
    .rom_en(rom_en_v[1]), .rom_addr(rom_addr_v[1]), .rom_data(rom_data_v[1]),
    .starve_cnt(starve_v[1])
  );

  // ROM models: data valid LAT cycles after rom_en, garbage otherwise.
  always @(posedge clk) begin
    pa[0] <= rom_en_v[0] ? rom_img[rom_addr_v[0]] : 8'($urandom);
    for (int i = 1; i < LAT_A; i++) pa[i] <= pa[i-1];
    pb[0] <= rom_en_v[1] ? rom_img[rom_addr_v[1]] : 8'($urandom);
    for (int i = 1; i < LAT_B; i++) pb[i] <= pb[i-1];
  end
  assign rom_data_v[0] = pa[LAT_A-1];
  assign rom_data_v[1] = pb[LAT_B-1];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got 0x%0h required 0x%0h", nm, d, cyc, act, req);
    end
  endtask

  // Requesters: hold req/addr until granted, optionally drop a request for a cycle.
  always @(posedge clk) begin
    #1;
    if (gnt0_v[0] && jobs0.size() > 0) void'(jobs0.pop_front());
    if (gnt1_v[0] && jobs1.size() > 0) void'(jobs1.pop_front());
    req0  = (jobs0.size() > 0) && ($urandom_range(99) >= drop_pct);
    req1  = (jobs1.size() > 0) && ($urandom_range(99) >= drop_pct);
    addr0 = (jobs0.size() > 0) ? jobs0[0] : 11'($urandom);
    addr1 = (jobs1.size() > 0) ? jobs1[0] : 11'($urandom);
  end

  // Reference model: req0 wins unless req1 has already lost MAX_WAIT times.
  always @(posedge clk) begin
    gexp_t g;
    exp_t  e;
    int    w;
    cyc++;
    g.g0 = 1'b0; g.g1 = 1'b0; g.a = '0; g.sc = '0;
    if (!rst) begin
      waitc = 0;
      for (int d = 0; d < 2; d++)
        for (int o = 0; o < 2; o++) begin
          sb[d][o].delete();
          last[d][o] = '0;
        end
    end else begin
      w = -1;
      if (req1 && waitc >= MAX_WAIT) w = 1;
      else if (req0)                 w = 0;
      else if (req1)                 w = 1;
      if (w == 1 || !req1)       waitc = 0;
      else if (waitc < MAX_WAIT) waitc = waitc + 1;
      g.sc = 4'(waitc);
      if (w == 0) begin g.g0 = 1'b1; g.a = addr0; end
      if (w == 1) begin g.g1 = 1'b1; g.a = addr1; end
      if (w >= 0) begin
        e.data = rom_img[g.a];
        e.due  = cyc + LAT_A + 1;
        sb[0][w].push_back(e);
        e.due  = cyc + LAT_B + 1;
        sb[1][w].push_back(e);
      end
    end
    gq.push_back(g);
  end

  // Monitor: compares DUT outputs against the queued expectations.
  always @(negedge clk) begin
    gexp_t      g;
    exp_t       e;
    logic       rv;
    logic [7:0] rd;
    if (gq.size() > 0) begin
      g = gq.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk("gnt0", d, 32'(gnt0_v[d]), 32'(g.g0));
        chk("gnt1", d, 32'(gnt1_v[d]), 32'(g.g1));
        chk("rom_en", d, 32'(rom_en_v[d]), 32'(g.g0 | g.g1));
        if (g.g0 || g.g1) chk("rom_addr", d, 32'(rom_addr_v[d]), 32'(g.a));
        chk("starve_cnt", d, 32'(starve_v[d]), 32'(g.sc));
        chk("rvalid_overlap", d, 32'(rvalid0_v[d] & rvalid1_v[d]), 32'(0));
        for (int o = 0; o < 2; o++) begin
          rv = (o == 0) ? rvalid0_v[d] : rvalid1_v[d];
          rd = (o == 0) ? rdata0_v[d] : rdata1_v[d];
          if (rv) begin
            if (sb[d][o].size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL rvalid_unexpected dut%0d owner%0d @cyc %0d: got pulse, required none", d, o, cyc);
            end else begin
              e = sb[d][o].pop_front();
              chk("rvalid_cycle", d, 32'(cyc), 32'(e.due));
              last[d][o] = e.data;
            end
          end else if (sb[d][o].size() > 0 && sb[d][o][0].due <= cyc) begin
            n_chk++; n_fail++;
            $display("FAIL rvalid_missing dut%0d owner%0d @cyc %0d: got none, required pulse", d, o, cyc);
            void'(sb[d][o].pop_front());
          end
          chk(o == 0 ? "rdata0" : "rdata1", d, 32'(rd), 32'(last[d][o]));
        end
      end
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while ((jobs0.size() > 0 || jobs1.size() > 0 ||
            sb[0][0].size() > 0 || sb[0][1].size() > 0 ||
            sb[1][0].size() > 0 || sb[1][1].size() > 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= maxc) begin
      n_fail++;
      $display("FAIL drain: still pending after %0d cycles, required empty", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_img[i] = 8'($urandom);

    // Reset held with req0 pending
    rst = 1'b0;
    jobs0.push_back(11'h055);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt0", d, 32'(gnt0_v[d]), 32'(0));
      chk("rst_rom_en", d, 32'(rom_en_v[d]), 32'(0));
      chk("rst_rvalid0", d, 32'(rvalid0_v[d]), 32'(0));
      chk("rst_rdata0", d, 32'(rdata0_v[d]), 32'(0));
    end
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_gnt0", 0, 32'(gnt0_v[0]), 32'(1));
    chk("rel_rom_addr", 0, 32'(rom_addr_v[0]), 32'h055);
    drain(50);

    // req0 only, sequential burst
    for (int i = 0; i < 8; i++) jobs0.push_back(11'(32'h100 + i));
    drain(100);

    // both held: 0,0,0,0,1 pattern
    for (int i = 0; i < 40; i++) jobs0.push_back(11'(32'h200 + i));
    for (int i = 0; i < 8; i++)  jobs1.push_back(11'(32'h600 + i));
    drain(300);

    // req1 stream, req0 arrives mid-stream
    for (int i = 0; i < 8; i++) jobs1.push_back(11'(32'h700 + i));
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) jobs0.push_back(11'(32'h300 + i));
    drain(200);

    // alternating requesters
    for (int i = 0; i < 4; i++) begin
      jobs0.push_back(11'(32'h400 + i));
      @(negedge clk);
      jobs1.push_back(11'(32'h500 + i));
      @(negedge clk);
    end
    drain(200);

    // reset with reads in flight
    for (int i = 0; i < 3; i++) jobs0.push_back(11'(32'h0A0 + i));
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    jobs1.push_back(11'h3AA);
    drain(200);

    // random traffic with dropped requests
    drop_pct = 20;
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) jobs0.push_back(11'($urandom));
      if ($urandom_range(3) == 0) jobs1.push_back(11'($urandom));
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
